fnorm32: RTL and testbench
==========================

FNORM32 -- requirements
Module: fnorm32

Interface
REQ-001 Parameter: ZERO_ON_UNDERFLOW, default 1, 1 = flush underflowed results to signed zero, 0 = emit exponent 0 with the current mantissa bits.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  reset is synchronous and active-high.
REQ-004 in_valid  input  1  upstream raw sum valid.
REQ-005 in_ready  output  1  block can accept a raw sum; equals (state == IDLE).
REQ-006 in_sign  input  1  sign of raw sum.
REQ-007 in_exp  input  8  biased exponent of the larger operand.
REQ-008 in_mant  input  25  raw mantissa sum; bit 24 = carry out, bit 23 = hidden-bit position.
REQ-009 out_valid  output  1  Result/ALUFlags valid.
REQ-010 out_ready  input  1  downstream accepts the result.
REQ-011 Result  output  32  packed IEEE-754 single, {sign, exp[7:0], mant[22:0]}.
REQ-012 ALUFlags  output  4  {neg, zero, carry, overflow}.
REQ-013 busy  output  1  high whenever state != IDLE.

Function
REQ-014 The FSM SHALL have three states: IDLE, NORM and DONE; only one operation is in flight at a time.
REQ-015 IDLE: when in_valid is high, the block SHALL capture sign, exp and mant into internal registers, latch carry_r = in_mant[24], and move to NORM; otherwise it stays in IDLE.
REQ-016 NORM, rule 1: if captured exp == 8'hFF, the block SHALL pass the value through as {sign, 8'hFF, mant[22:0]} with overflow=1, and go to DONE.
REQ-017 NORM, rule 2: else if mant == 0, Result SHALL be {sign, 31'h0}; go to DONE.
REQ-018 NORM, rule 3: else if mant[24] is set and exp == 8'hFE, Result SHALL be {sign, 8'hFF, 23'h0} with overflow=1; go to DONE.
REQ-019 NORM, rule 4: else if mant[24] is set, the block SHALL shift mant right by 1 (truncate the LSB), increment exp, and go to DONE in the same cycle.
REQ-020 NORM, rule 5: else if mant[23] is set, the mantissa is already normalized; go to DONE.
REQ-021 NORM, rule 6: else if exp <= 1 (underflow), exp SHALL become 0, and mant SHALL become 0 if ZERO_ON_UNDERFLOW=1 or be kept unchanged if 0; go to DONE.
REQ-022 NORM, rule 7: otherwise the block SHALL shift mant left by 1, decrement exp, and stay in NORM; it performs exactly one shift per cycle.
REQ-023 NORM rules SHALL be evaluated in priority order: rule 1 first, rule 7 last.
REQ-024 Latency: with an accept edge k and s left shifts, out_valid SHALL rise after edge k+1+s; minimum 2 cycles, maximum 25 cycles (s=23).
REQ-025 DONE: out_valid=1; Result and ALUFlags SHALL be held stable until the handshake completes.
REQ-026 DONE: on out_ready=1 the block SHALL return to IDLE at the next edge; out_valid drops and in_ready rises.
REQ-027 in_valid asserted during NORM or DONE SHALL be ignored and not captured; the upstream stage holds its data until in_ready is high.
REQ-028 Flags: neg = Result[31]; zero = (Result[30:0] == 0); carry = carry_r; overflow = (Result[30:23] == 8'hFF).
REQ-029 All exponent arithmetic SHALL be 8-bit and cannot wrap, because rules 3 and 6 guard both ends of the range.

Reset
REQ-030 When reset=1 at an edge: state becomes IDLE, out_valid=0, Result=32'h0, ALUFlags=4'h0, and all internal registers are cleared.
REQ-031 A reset during NORM or DONE SHALL abort the operation with no out_valid pulse; in_ready=1 from the first edge after reset is deasserted.
REQ-032 reset SHALL take priority over in_valid and out_ready at the same edge.

Verification
REQ-033 Already-normalized input: sign=0, exp=8'h80, mant=25'h0C00000 -> out_valid 2 cycles after accept, Result=32'h40400000, ALUFlags=4'b0000.
REQ-034 Carry input: sign=0, exp=8'h7F, mant=25'h1800000 -> 2 cycles later, Result=32'h40400000, ALUFlags=4'b0010.
REQ-035 Cancellation: sign=0, exp=8'h85, mant=25'h0000100 -> 15 left shifts, out_valid 17 cycles after accept, Result=32'h3B000000.
REQ-036 Zero and underflow cases:
- sign=1, exp=8'h90, mant=0 -> Result=32'h80000000, ALUFlags=4'b1100.
- sign=0, exp=8'h02, mant=25'h0200000, ZERO_ON_UNDERFLOW=1 -> Result=32'h00000000, zero=1.
REQ-037 Overflow: sign=0, exp=8'hFE, mant=25'h1000000 -> Result=32'h7F800000, ALUFlags=4'b0011.
REQ-038 Backpressure and reset:
- Hold out_ready=0 for 10 cycles in DONE -> Result stable, in_ready=0, and a new in_valid is not captured.
- Assert reset for 1 cycle mid-NORM -> out_valid never pulses, and in_ready=1 on the next cycle.

Source files
------------

// File: rtl/fnorm32.sv
// Post-add normalizer: takes a raw 25-bit mantissa sum and emits a packed
// IEEE-754 single plus {neg, zero, carry, overflow} flags, one shift per cycle.
module fnorm32 #(
  parameter bit ZERO_ON_UNDERFLOW = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_sign,
  input  logic [7:0]  in_exp,
  input  logic [24:0] in_mant,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] Result,
  output logic [3:0]  ALUFlags,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, NORM, DONE} state_t;

  state_t      state;
  logic        sign_r;
  logic        carry_r;
  logic [7:0]  exp_r;
  logic [24:0] mant_r;

  logic        norm_fin;
  logic [31:0] norm_res;
  logic [3:0]  norm_flags;
  logic [7:0]  nxt_exp;
  logic [24:0] nxt_mant;

  // Priority-ordered normalization rules for the current NORM cycle.
  always_comb begin
    norm_fin = 1'b1;
    nxt_exp  = exp_r;
    nxt_mant = mant_r;
    norm_res = {sign_r, exp_r, mant_r[22:0]};
    if (exp_r == 8'hFF) begin
      norm_res = {sign_r, 8'hFF, mant_r[22:0]};
    end else if (mant_r == 25'h0) begin
      norm_res = {sign_r, 31'h0};
    end else if (mant_r[24] && exp_r == 8'hFE) begin
      norm_res = {sign_r, 8'hFF, 23'h0};
    end else if (mant_r[24]) begin
      nxt_mant = {1'b0, mant_r[24:1]};
      nxt_exp  = exp_r + 8'd1;
      norm_res = {sign_r, nxt_exp, nxt_mant[22:0]};
    end else if (mant_r[23]) begin
      norm_res = {sign_r, exp_r, mant_r[22:0]};
    end else if (exp_r <= 8'd1) begin
      nxt_exp  = 8'h00;
      nxt_mant = ZERO_ON_UNDERFLOW ? 25'h0 : mant_r;
      norm_res = {sign_r, 8'h00, nxt_mant[22:0]};
    end else begin
      norm_fin = 1'b0;
      nxt_mant = {mant_r[23:0], 1'b0};
      nxt_exp  = exp_r - 8'd1;
    end
    norm_flags = {norm_res[31], (norm_res[30:0] == 31'h0), carry_r,
                  (norm_res[30:23] == 8'hFF)};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      sign_r    <= 1'b0;
      carry_r   <= 1'b0;
      exp_r     <= 8'h00;
      mant_r    <= 25'h0;
      out_valid <= 1'b0;
      Result    <= 32'h0;
      ALUFlags  <= 4'h0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            sign_r  <= in_sign;
            exp_r   <= in_exp;
            mant_r  <= in_mant;
            carry_r <= in_mant[24];
            state   <= NORM;
          end
        end
        NORM: begin
          exp_r  <= nxt_exp;
          mant_r <= nxt_mant;
          if (norm_fin) begin
            Result    <= norm_res;
            ALUFlags  <= norm_flags;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          // Result/ALUFlags stay put until the consumer takes them.
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);

endmodule

// File: tb/tb_fnorm32.sv
// Randomized scoreboard bench for fnorm32 against an arithmetic reference model.
module tb_fnorm32;

  localparam bit ZOU = 1'b1;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic        in_sign;
  logic [7:0]  in_exp;
  logic [24:0] in_mant;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] Result;
  logic [3:0]  ALUFlags;
  logic        busy;

  fnorm32 #(.ZERO_ON_UNDERFLOW(ZOU)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_sign(in_sign), .in_exp(in_exp), .in_mant(in_mant),
    .out_valid(out_valid), .out_ready(out_ready), .Result(Result),
    .ALUFlags(ALUFlags), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    logic [3:0]  fl;
    int          shifts;
    int          acc;
  } exp_t;

  exp_t        sb[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  int          hold_cnt = 0;
  logic        prev_valid = 1'b0;
  logic [31:0] held_res;
  logic [3:0]  held_fl;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: normalize with plain integer arithmetic.
  function automatic void model(input bit s, input logic [7:0] e, input logic [24:0] m,
                                output logic [31:0] res, output logic [3:0] fl,
                                output int sh);
    int          ei;
    longint      mi;
    logic [7:0]  eb;
    logic [31:0] mb;
    ei = int'(e);
    mi = longint'(m);
    sh = 0;
    if (ei == 255) begin
      res = {s, 8'hFF, m[22:0]};
    end else if (mi == 0) begin
      res = {s, 31'h0};
    end else if (mi >= 64'd16777216) begin
      if (ei == 254) res = {s, 8'hFF, 23'h0};
      else begin
        mi = mi / 2;
        ei = ei + 1;
        eb = ei[7:0];
        mb = mi[31:0];
        res = {s, eb, mb[22:0]};
      end
    end else begin
      while (mi < 64'd8388608 && ei > 1) begin
        mi = mi * 2;
        ei = ei - 1;
        sh++;
      end
      eb = ei[7:0];
      mb = mi[31:0];
      if (mi >= 64'd8388608) res = {s, eb, mb[22:0]};
      else if (ZOU) res = {s, 31'h0};
      else res = {s, 8'h00, mb[22:0]};
    end
    fl = {res[31], (res[30:0] == 31'h0), m[24], (res[30:23] == 8'hFF)};
  endfunction

  task automatic send(input bit s, input logic [7:0] e, input logic [24:0] m);
    exp_t x;
    int   t;
    @(negedge clk);
    in_sign  = s;
    in_exp   = e;
    in_mant  = m;
    in_valid = 1'b1;
    t = 0;
    while (!in_ready && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL accept_timeout: in_ready=%b after %0d cycles, expected 1", in_ready, t);
    end else begin
      model(s, e, m, x.res, x.fl, x.shifts);
      x.acc = cyc + 1;
      sb.push_back(x);
    end
  endtask

  // Monitor: pops the scoreboard on each rising out_valid, checks hold stability.
  always @(negedge clk) begin
    exp_t x;
    if (reset) begin
      prev_valid = 1'b0;
      out_ready  = 1'b0;
    end else begin
      if (out_valid) begin
        chk("in_ready_in_done", {31'h0, in_ready}, 32'h0);
        if (!prev_valid) begin
          if (sb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL spurious_valid: out_valid=1 with Result %h, expected no output", Result);
          end else begin
            x = sb.pop_front();
            chk("result", Result, x.res);
            chk("flags", {28'h0, ALUFlags}, {28'h0, x.fl});
            chk("latency", cyc - x.acc, 1 + x.shifts);
          end
          held_res = Result;
          held_fl  = ALUFlags;
        end else begin
          chk("hold_result", Result, held_res);
          chk("hold_flags", {28'h0, ALUFlags}, {28'h0, held_fl});
        end
      end
      prev_valid = out_valid;
      if (hold_cnt > 0) begin
        out_ready = 1'b0;
        if (out_valid) hold_cnt--;
      end else begin
        out_ready = ($urandom_range(0, 3) != 0);
      end
    end
  end

  initial begin
    logic [7:0]  e;
    logic [24:0] m;
    logic [31:0] mask;
    logic        seen;
    int          w;
    int          t;

    reset = 1'b1; in_valid = 1'b0; in_sign = 1'b0; in_exp = 8'h00; in_mant = 25'h0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", {31'h0, out_valid}, 32'h0);
    chk("rst_result", Result, 32'h0);
    chk("rst_flags", {28'h0, ALUFlags}, 32'h0);
    chk("rst_in_ready", {31'h0, in_ready}, 32'h1);
    chk("rst_busy", {31'h0, busy}, 32'h0);

    hold_cnt = 10;
    send(1'b0, 8'h80, 25'h0C00000);
    send(1'b0, 8'h7F, 25'h1800000);
    send(1'b0, 8'h85, 25'h0000100);
    send(1'b1, 8'h90, 25'h0000000);
    send(1'b0, 8'h02, 25'h0200000);
    send(1'b0, 8'hFE, 25'h1000000);
    send(1'b1, 8'hFF, 25'h0123456);
    send(1'b0, 8'h18, 25'h0000001);

    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 7))
        0: e = 8'h00;
        1: e = 8'h01;
        2: e = 8'h02;
        3: e = 8'hFE;
        4: e = 8'hFF;
        default: e = 8'($urandom);
      endcase
      w = $urandom_range(0, 25);
      mask = (32'h1 << w) - 32'h1;
      m = 25'($urandom & mask);
      if ($urandom_range(0, 4) == 0) begin
        @(negedge clk);
        in_valid = 1'b0;
      end
      send(1'($urandom), e, m);
    end

    @(negedge clk);
    in_valid = 1'b0;
    t = 0;
    while ((sb.size() != 0 || busy) && t < 3000) begin
      @(negedge clk);
      t++;
    end
    chk("drain", {31'h0, (sb.size() != 0 || busy)}, 32'h0);

    // Abort an operation mid-normalization.
    send(1'b0, 8'h85, 25'h0000100);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("mid_norm_busy", {31'h0, busy}, 32'h1);
    reset = 1'b1;
    sb.delete();
    @(negedge clk);
    reset = 1'b0;
    chk("abort_in_ready", {31'h0, in_ready}, 32'h1);
    chk("abort_result", Result, 32'h0);
    seen = 1'b0;
    repeat (30) begin
      @(negedge clk);
      seen = seen | out_valid;
    end
    chk("abort_no_valid", {31'h0, seen}, 32'h0);

    send(1'b0, 8'h7F, 25'h1800000);
    @(negedge clk);
    in_valid = 1'b0;
    t = 0;
    while ((sb.size() != 0 || busy) && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("post_reset_op", {31'h0, (sb.size() != 0 || busy)}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
